// File: rtl/logic_issue_stage.sv
// logic_issue_stage: operand issue stage in front of the 32-bit logical units.
// Requests {op, a, b, tag} arrive over valid/ready and are buffered in a
// small FIFO. Each request spends one EXEC cycle driving the operand buses
// and unit select. The selected unit's result is then captured and held
// downstream with its tag until it is accepted.
//
// Optional feature macro: LOGIC_ISSUE_ZDRIVE_EN
//   defined   : idle op_a/op_b are driven all-z, op_sel keeps its last value
//   undefined : idle op_a/op_b are 0, idle op_sel is 0
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          request handshake
//   in_op, in_a, in_b, in_tag  request fields (op 7 is illegal)
//   op_a, op_b, op_sel         operand buses and unit select
//   res_in                     result from the selected unit
//   out_valid/out_ready        result handshake
//   out_data, out_tag, out_err captured result, its tag, illegal-op flag
module logic_issue_stage #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic [2:0]       op_sel,
   input  logic [WIDTH-1:0] res_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      HOLD
   } state_t;

   state_t state;
   state_t state_nx;

   logic [2:0]       f_op  [DEPTH];
   logic [WIDTH-1:0] f_a   [DEPTH];
   logic [WIDTH-1:0] f_b   [DEPTH];
   logic [TAG_W-1:0] f_tag [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic full;
   logic empty;
   logic push;
   logic pop;

   logic [2:0]       h_op;
   logic [WIDTH-1:0] h_a;
   logic [WIDTH-1:0] h_b;
   logic [TAG_W-1:0] h_tag;
   logic             h_ill;

   logic [WIDTH-1:0] exe_a;
   logic [WIDTH-1:0] exe_b;

   // Full comes from the registered count, so a pop in the same cycle
   // never opens a slot for a push.
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign in_ready = !full && !rst;
   assign push     = in_valid && in_ready;
   // EXEC is only entered with a non-empty FIFO, so the head is valid.
   assign pop      = (state == EXEC);

   assign h_op  = f_op[rd_ptr];
   assign h_a   = f_a[rd_ptr];
   assign h_b   = f_b[rd_ptr];
   assign h_tag = f_tag[rd_ptr];
   assign h_ill = (h_op == 3'd7);

   // Illegal op drives both buses low; NOT uses only a, so b is zeroed.
   assign exe_a = h_ill ? '0 : h_a;
   assign exe_b = (h_ill || h_op == 3'd6) ? '0 : h_b;

   always_ff @(posedge clk) begin
      if (push) begin
         f_op[wr_ptr]  <= in_op;
         f_a[wr_ptr]   <= in_a;
         f_b[wr_ptr]   <= in_b;
         f_tag[wr_ptr] <= in_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
         out_err   <= 1'b0;
      end else begin
         state <= state_nx;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         if (pop) begin
            out_valid <= 1'b1;
            out_data  <= h_ill ? '0 : res_in;
            out_tag   <= h_tag;
            out_err   <= h_ill;
         end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               state_nx = EXEC;
            end
         end
         EXEC: begin
            state_nx = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               state_nx = empty ? IDLE : EXEC;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

`ifdef LOGIC_ISSUE_ZDRIVE_EN
   logic [2:0] sel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q <= '0;
      end else if (pop) begin
         sel_q <= h_op;
      end
   end

   assign op_a   = pop ? exe_a : 'z;
   assign op_b   = pop ? exe_b : 'z;
   assign op_sel = pop ? h_op : sel_q;
`else
   assign op_a   = pop ? exe_a : '0;
   assign op_b   = pop ? exe_b : '0;
   assign op_sel = pop ? h_op : 3'd0;
`endif

endmodule

// File: tb/tb_logic_issue_stage.sv
// tb_logic_issue_stage: randomized and directed bench for logic_issue_stage.
// A queue-based reference model predicts every output on every cycle.
module tb_logic_issue_stage;

   localparam int WIDTH = 32;
   localparam int DEPTH = 2;
   localparam int TAG_W = 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [TAG_W-1:0] in_tag;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [2:0]       op_sel;
   logic [WIDTH-1:0] res_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_err;

   logic_issue_stage #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .TAG_W(TAG_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_op(in_op),
      .in_a(in_a),
      .in_b(in_b),
      .in_tag(in_tag),
      .op_a(op_a),
      .op_b(op_b),
      .op_sel(op_sel),
      .res_in(res_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_tag(out_tag),
      .out_err(out_err)
   );

`ifdef LOGIC_ISSUE_ZDRIVE_EN
   localparam logic [WIDTH-1:0] IDLE_V = 'z;
   localparam bit ZD = 1'b1;
`else
   localparam logic [WIDTH-1:0] IDLE_V = '0;
   localparam bit ZD = 1'b0;
`endif

   typedef struct {
      logic [2:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TAG_W-1:0] tag;
   } req_t;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic [TAG_W-1:0] t;
      logic             e;
      int               c;
   } res_t;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int acc_edge = 0;

   req_t mq[$];
   res_t got[$];
   bit               m_exec = 0;
   bit               m_have = 0;
   logic [WIDTH-1:0] m_data = '0;
   logic [TAG_W-1:0] m_tag = '0;
   bit               m_err = 0;
   logic [2:0]       m_sel = '0;

   logic [WIDTH-1:0] exp6 [6];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Logical units: combinational from the operand buses; op 7 gives junk.
   always_comb begin
      res_in = 32'hDEAD_BEEF;
      case (op_sel)
         3'd0: res_in = op_a & op_b;
         3'd1: res_in = op_a | op_b;
         3'd2: res_in = op_a ^ op_b;
         3'd3: res_in = ~(op_a & op_b);
         3'd4: res_in = ~(op_a | op_b);
         3'd5: res_in = ~(op_a ^ op_b);
         3'd6: res_in = ~op_a;
         default: res_in = 32'hDEAD_BEEF;
      endcase
   end

   function automatic logic [WIDTH-1:0] lres(input req_t r);
      case (r.op)
         3'd0: return r.a & r.b;
         3'd1: return r.a | r.b;
         3'd2: return r.a ^ r.b;
         3'd3: return ~(r.a & r.b);
         3'd4: return ~(r.a | r.b);
         3'd5: return ~(r.a ^ r.b);
         3'd6: return ~r.a;
         default: return '0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Compare process plus reference model, evaluated once per cycle.
   always @(negedge clk) begin
      req_t h;
      req_t r;
      logic [WIDTH-1:0] ea;
      logic [WIDTH-1:0] eb;
      logic [2:0] es;
      bit er;
      bit nonempty;
      bit nx_exec;
      er = !rst && (mq.size() < DEPTH);
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("out_valid", 32'(out_valid), 32'(m_have));
      chk("out_data", out_data, m_data);
      chk("out_tag", 32'(out_tag), 32'(m_tag));
      chk("out_err", 32'(out_err), 32'(m_err));
      if (m_exec) begin
         h = mq[0];
         ea = (h.op == 3'd7) ? '0 : h.a;
         eb = (h.op >= 3'd6) ? '0 : h.b;
         es = h.op;
      end else begin
         ea = IDLE_V;
         eb = IDLE_V;
         es = ZD ? m_sel : 3'd0;
      end
      chk("op_a", op_a, ea);
      chk("op_b", op_b, eb);
      chk("op_sel", 32'(op_sel), 32'(es));
      if (!rst && out_valid && out_ready) begin
         got.push_back('{out_data, out_tag, out_err, cyc});
      end
      if (rst) begin
         mq.delete();
         m_exec = 0;
         m_have = 0;
         m_data = '0;
         m_tag = '0;
         m_err = 0;
         m_sel = '0;
      end else begin
         nonempty = (mq.size() > 0);
         nx_exec = 0;
         if (m_exec) begin
            r = mq.pop_front();
            m_data = lres(r);
            m_tag = r.tag;
            m_err = (r.op == 3'd7);
            m_sel = r.op;
            m_have = 1;
         end else if (m_have) begin
            if (out_ready) begin
               m_have = 0;
               nx_exec = nonempty;
            end
         end else begin
            nx_exec = nonempty;
         end
         m_exec = nx_exec;
         if (in_valid && er) begin
            mq.push_back('{in_op, in_a, in_b, in_tag});
            acc_edge = cyc + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
      bit ok;
      ok = 0;
      in_valid = 1'b1;
      in_op = op;
      in_a = a;
      in_b = b;
      in_tag = tag;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         step();
      end
      in_valid = 1'b0;
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL push_timeout tag %0d: in_ready stayed 0, required 1", tag);
      end
   endtask

   task automatic wait_got(input int n);
      int i;
      i = 0;
      while (got.size() < n && i < 300) begin
         step();
         i++;
      end
      tests++;
      if (got.size() < n) begin
         fails++;
         $display("FAIL wait_results: got %0d results, required %0d", got.size(), n);
      end
   endtask

   initial begin
      int a0;
      rst = 1'b1;
      in_valid = 1'b0;
      in_op = '0;
      in_a = '0;
      in_b = '0;
      in_tag = '0;
      out_ready = 1'b1;
      exp6 = '{32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h0F0F_0F0F,
               32'h0000_0000, 32'hF0F0_F0F0, 32'h0000_0000};
      step();
      step();
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_op_sel", 32'(op_sel), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_op_a", op_a, IDLE_V);
      step();
      rst = 1'b0;

      // Single AND, latency check
      got.delete();
      push(3'd0, 32'h3333_3333, 32'hCCCC_CCCC, 4'd3);
      a0 = acc_edge;
      wait_got(1);
      chk("t1_data", got[0].d, 32'h0);
      chk("t1_tag", 32'(got[0].t), 32'd3);
      chk("t1_err", 32'(got[0].e), 32'd0);
      chk("t1_latency", 32'(got[0].c - a0), 32'd2);
      repeat (3) step();

      // Ops 1..6 back to back
      got.delete();
      for (int i = 1; i <= 6; i++) begin
         push(3'(i), 32'hFFFF_FFFF, 32'hF0F0_F0F0, 4'(i));
      end
      wait_got(6);
      for (int i = 0; i < 6; i++) begin
         chk("t2_data", got[i].d, exp6[i]);
         chk("t2_tag", 32'(got[i].t), 32'(i + 1));
         if (i > 0) begin
            chk("t2_spacing", 32'(got[i].c - got[i-1].c), 32'd2);
         end
      end
      repeat (3) step();

      // Backpressure: FIFO fills behind a held result
      got.delete();
      out_ready = 1'b0;
      push(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd10);
      push(3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd11);
      push(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd12);
      in_valid = 1'b1;
      in_op = 3'd5;
      in_a = 32'hF0F0_F0F0;
      in_b = 32'hFF00_FF00;
      in_tag = 4'd13;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_full", 32'(in_ready), 32'd0);
         step();
      end
      out_ready = 1'b1;
      push(3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd13);
      wait_got(4);
      chk("t3_d0", got[0].d, 32'hF000_F000);
      chk("t3_d1", got[1].d, 32'hFFF0_FFF0);
      chk("t3_d2", got[2].d, 32'h0FF0_0FF0);
      chk("t3_d3", got[3].d, 32'hF00F_F00F);
      for (int i = 0; i < 4; i++) begin
         chk("t3_tag", 32'(got[i].t), 32'(10 + i));
      end
      repeat (3) step();

      // Illegal op then a legal XOR
      got.delete();
      push(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 4'd9);
      push(3'd2, 32'h5555_5555, 32'hAAAA_AAAA, 4'd5);
      wait_got(2);
      chk("t4_err", 32'(got[0].e), 32'd1);
      chk("t4_data", got[0].d, 32'h0);
      chk("t4_tag", 32'(got[0].t), 32'd9);
      chk("t4_err2", 32'(got[1].e), 32'd0);
      chk("t4_data2", got[1].d, 32'hFFFF_FFFF);
      repeat (3) step();

      // Reset while holding a result with one entry queued
      got.delete();
      out_ready = 1'b0;
      push(3'd1, 32'h0000_00FF, 32'h0000_FF00, 4'd1);
      push(3'd3, 32'h0000_00FF, 32'h0000_FF00, 4'd2);
      step();
      step();
      @(negedge clk);
      chk("t5_holding", 32'(out_valid), 32'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_op_a", op_a, IDLE_V);
      chk("t5_in_ready", 32'(in_ready), 32'd1);
      step();
      out_ready = 1'b1;
      repeat (10) step();
      chk("t5_no_stale", 32'(got.size()), 32'd0);

      // Idle buses
      @(negedge clk);
      chk("idle_op_a", op_a, IDLE_V);
      chk("idle_op_b", op_b, IDLE_V);
      chk("idle_op_sel", 32'(op_sel), 32'd0);
      step();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(99) == 0);
         in_valid = ($urandom_range(9) < 7);
         in_op = 3'($urandom);
         in_a = $urandom;
         in_b = $urandom;
         in_tag = 4'($urandom);
         out_ready = ($urandom_range(9) < 6);
         step();
      end
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (20) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
